// File: rtl/ins_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ins_pkg
// Description : Shared constants for the instruction sequencer: state
//               encoding, op-register bit indices and watchdog defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package ins_pkg;

    localparam int c_wait_max_default = 15;
    localparam int c_cw_default       = 4;

    typedef logic [2:0] state_t;

    localparam state_t c_st_idle    = 3'd0;
    localparam state_t c_st_fetch   = 3'd1;
    localparam state_t c_st_decode  = 3'd2;
    localparam state_t c_st_operand = 3'd3;
    localparam state_t c_st_exec    = 3'd4;
    localparam state_t c_st_wait_io = 3'd5;
    localparam state_t c_st_halt    = 3'd6;
    localparam state_t c_st_err     = 3'd7;

    // Bit index equals the opcode after folding 11xx onto 00xx
    localparam int c_op_in1  = 0;
    localparam int c_op_out1 = 1;
    localparam int c_op_movi = 2;
    localparam int c_op_halt = 3;
    localparam int c_op_mova = 4;
    localparam int c_op_movb = 5;
    localparam int c_op_movc = 6;
    localparam int c_op_movd = 7;
    localparam int c_op_add  = 8;
    localparam int c_op_sub  = 9;
    localparam int c_op_jmp  = 10;
    localparam int c_op_jg   = 11;
    localparam int c_op_w    = 12;

    typedef logic [c_op_w-1:0] op_t;

endpackage : ins_pkg
`default_nettype wire

// File: rtl/ins_decode.sv
`default_nettype none
// ============================================================================
// Module      : ins_decode
// Description : Opcode decoder producing a one-hot op vector when enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module ins_decode
    import ins_pkg::*;
(
    input  logic              en,
    input  logic [3:0]        ir,
    output logic [c_op_w-1:0] op
);

    logic [1:0] w_grp;
    logic [3:0] w_idx;

    // Group 11 aliases group 00
    assign w_grp = (ir[3:2] == 2'b11) ? 2'b00 : ir[3:2];
    assign w_idx = {w_grp, ir[1:0]};

    always_comb begin
        op = '0;
        if (en) begin
            op = op_t'(1) << w_idx;
        end
    end

endmodule : ins_decode
`default_nettype wire

// File: rtl/ins_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ins_sequencer
// Description : Multi-cycle instruction control sequencer with handshake
//               watchdog and sticky error state.
// Revision    : 1.0 - initial release
// ============================================================================
module ins_sequencer
    import ins_pkg::*;
#(
    parameter int WAIT_MAX = c_wait_max_default,
    parameter int CW       = c_cw_default
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] ir,
    input  logic       gt_flag,
    input  logic       mem_ready,
    input  logic       in_valid,
    input  logic       out_ready,
    output logic       mem_rd,
    output logic       ir_ld,
    output logic       imm_ld,
    output logic       pc_inc,
    output logic       pc_ld,
    output logic       reg_wr,
    output logic       alu_en,
    output logic       alu_sub,
    output logic       io_in_ack,
    output logic       io_out_vld,
    output logic       retire,
    output logic       halted,
    output logic       err
);

    state_t              r_state;
    state_t              w_state_nxt;
    op_t                 r_op;
    op_t                 w_dec_op;
    logic                w_dec_en;
    logic [CW-1:0]       r_wd;
    logic                r_halt_seen;
    logic                w_stall;
    logic                w_wd_trip;

    ins_decode u_decode (
        .en (w_dec_en),
        .ir (ir),
        .op (w_dec_op)
    );

    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            c_st_fetch,
            c_st_operand: w_stall = ~mem_ready;
            c_st_wait_io: w_stall = r_op[c_op_in1] ? ~in_valid : ~out_ready;
            default:      w_stall = 1'b0;
        endcase
    end

    // Trips on the stalled cycle that would bring the count to WAIT_MAX
    assign w_wd_trip = w_stall && (r_wd == CW'(WAIT_MAX - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_op        <= '0;
            r_wd        <= '0;
            r_halt_seen <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_halt_seen <= (r_state == c_st_halt);
            if (r_state == c_st_decode) begin
                r_op <= w_dec_op;
            end
            if (w_stall) begin
                r_wd <= r_wd + CW'(1);
            end else begin
                r_wd <= '0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dec_en    = 1'b0;
        mem_rd      = 1'b0;
        ir_ld       = 1'b0;
        imm_ld      = 1'b0;
        pc_inc      = 1'b0;
        pc_ld       = 1'b0;
        reg_wr      = 1'b0;
        alu_en      = 1'b0;
        alu_sub     = 1'b0;
        io_in_ack   = 1'b0;
        io_out_vld  = 1'b0;
        retire      = 1'b0;
        halted      = 1'b0;
        err         = 1'b0;

        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_state_nxt = c_st_fetch;
                end
            end

            c_st_fetch: begin
                mem_rd = 1'b1;
                if (w_wd_trip) begin
                    w_state_nxt = c_st_err;
                end else if (mem_ready) begin
                    ir_ld       = 1'b1;
                    pc_inc      = 1'b1;
                    w_state_nxt = c_st_decode;
                end
            end

            c_st_decode: begin
                w_dec_en = 1'b1;
                if (w_dec_op[c_op_jmp] || w_dec_op[c_op_jg] || w_dec_op[c_op_movi]) begin
                    w_state_nxt = c_st_operand;
                end else if (w_dec_op[c_op_in1] || w_dec_op[c_op_out1]) begin
                    w_state_nxt = c_st_wait_io;
                end else if (w_dec_op[c_op_halt]) begin
                    w_state_nxt = c_st_halt;
                end else begin
                    w_state_nxt = c_st_exec;
                end
            end

            c_st_operand: begin
                mem_rd = 1'b1;
                if (w_wd_trip) begin
                    w_state_nxt = c_st_err;
                end else if (mem_ready) begin
                    imm_ld      = 1'b1;
                    pc_inc      = 1'b1;
                    w_state_nxt = c_st_exec;
                end
            end

            c_st_exec: begin
                retire      = 1'b1;
                w_state_nxt = c_st_fetch;
                reg_wr      = r_op[c_op_mova] | r_op[c_op_movb] | r_op[c_op_movc] |
                              r_op[c_op_movd] | r_op[c_op_add]  | r_op[c_op_sub]  |
                              r_op[c_op_movi];
                alu_en      = r_op[c_op_add] | r_op[c_op_sub];
                alu_sub     = r_op[c_op_sub];
                pc_ld       = r_op[c_op_jmp] | (r_op[c_op_jg] & gt_flag);
            end

            c_st_wait_io: begin
                if (r_op[c_op_in1]) begin
                    if (in_valid) begin
                        io_in_ack   = 1'b1;
                        reg_wr      = 1'b1;
                        retire      = 1'b1;
                        w_state_nxt = c_st_fetch;
                    end else if (w_wd_trip) begin
                        w_state_nxt = c_st_err;
                    end
                end else begin
                    io_out_vld = 1'b1;
                    if (out_ready) begin
                        retire      = 1'b1;
                        w_state_nxt = c_st_fetch;
                    end else if (w_wd_trip) begin
                        w_state_nxt = c_st_err;
                    end
                end
            end

            c_st_halt: begin
                halted = 1'b1;
                // The halt instruction retires once, on the cycle HALT is entered
                retire = r_op[c_op_halt] & ~r_halt_seen;
                if (start) begin
                    w_state_nxt = c_st_fetch;
                end
            end

            c_st_err: begin
                err = 1'b1;
            end

            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

endmodule : ins_sequencer
`default_nettype wire

// File: tb/tb_ins_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ins_sequencer
// Description : Scoreboard bench for ins_sequencer driven by an
//               instruction-level reference model with random stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ins_sequencer;

    localparam logic [12:0] E_MEMRD  = 13'h1000;
    localparam logic [12:0] E_IRLD   = 13'h0800;
    localparam logic [12:0] E_IMMLD  = 13'h0400;
    localparam logic [12:0] E_PCINC  = 13'h0200;
    localparam logic [12:0] E_PCLD   = 13'h0100;
    localparam logic [12:0] E_REGWR  = 13'h0080;
    localparam logic [12:0] E_ALUEN  = 13'h0040;
    localparam logic [12:0] E_ALUSUB = 13'h0020;
    localparam logic [12:0] E_INACK  = 13'h0010;
    localparam logic [12:0] E_OUTVLD = 13'h0008;
    localparam logic [12:0] E_RETIRE = 13'h0004;
    localparam logic [12:0] E_HALTED = 13'h0002;
    localparam logic [12:0] E_ERR    = 13'h0001;

    localparam int K_IN1 = 0, K_OUT1 = 1, K_MOVI = 2, K_HALT = 3, K_MOV = 4;
    localparam int K_ADD = 5, K_SUB = 6, K_JMP = 7, K_JG = 8;

    typedef struct {
        logic [12:0] v;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst, start, gt_flag, mem_ready, in_valid, out_ready;
    logic [3:0] ir;
    logic mem_rd, ir_ld, imm_ld, pc_inc, pc_ld, reg_wr, alu_en, alu_sub;
    logic io_in_ack, io_out_vld, retire, halted, err;
    logic [12:0] outs;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    ins_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .ir(ir), .gt_flag(gt_flag),
        .mem_ready(mem_ready), .in_valid(in_valid), .out_ready(out_ready),
        .mem_rd(mem_rd), .ir_ld(ir_ld), .imm_ld(imm_ld), .pc_inc(pc_inc),
        .pc_ld(pc_ld), .reg_wr(reg_wr), .alu_en(alu_en), .alu_sub(alu_sub),
        .io_in_ack(io_in_ack), .io_out_vld(io_out_vld), .retire(retire),
        .halted(halted), .err(err)
    );

    assign outs = {mem_rd, ir_ld, imm_ld, pc_inc, pc_ld, reg_wr, alu_en, alu_sub,
                   io_in_ack, io_out_vld, retire, halted, err};

    // Monitor: one expectation per cycle, compared mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                n_checks++;
                if (outs === e.v) n_pass++;
                else $display("FAIL %s t=%0t got=%h exp=%h", e.tag, $time, outs, e.v);
            end
        end
    end

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic int rw();
        int r;
        r = $urandom_range(0, 15);
        return (r == 15) ? 14 : (r % 4);
    endfunction

    // Opcode table: 00xx = in1,out1,movi,halt; 01xx = mov a-d;
    // 10xx = add,sub,jmp,jg; 11xx behaves as 00xx
    function automatic int kind_of(input logic [3:0] opc);
        logic [3:0] o;
        o = opc;
        if (o[3:2] == 2'b11) o[3:2] = 2'b00;
        case (o)
            4'd0:  return K_IN1;
            4'd1:  return K_OUT1;
            4'd2:  return K_MOVI;
            4'd3:  return K_HALT;
            4'd8:  return K_ADD;
            4'd9:  return K_SUB;
            4'd10: return K_JMP;
            4'd11: return K_JG;
            default: return K_MOV;
        endcase
    endfunction

    task automatic cyc(input logic s, input logic mr, input logic iv, input logic orr,
                       input logic g, input logic [12:0] e, input string tag);
        exp_t x;
        start = s; mem_ready = mr; in_valid = iv; out_ready = orr; gt_flag = g;
        x.v = e; x.tag = tag;
        expq.push_back(x);
        @(posedge clk); #1;
    endtask

    task automatic run_instr(input logic [3:0] opc, input int wf, input int wo,
                             input int wio, input int gsel, input int hold);
        int k;
        logic g;
        logic [12:0] ex;
        ir = opc;
        k  = kind_of(opc);
        for (int i = 0; i < wf; i++) cyc(rb(), 1'b0, rb(), rb(), rb(), E_MEMRD, "fetch_wait");
        cyc(rb(), 1'b1, rb(), rb(), rb(), E_MEMRD | E_IRLD | E_PCINC, "fetch");
        cyc(rb(), rb(), rb(), rb(), rb(), 13'h0, "decode");
        if (k == K_HALT) begin
            cyc(1'b0, rb(), rb(), rb(), rb(), E_HALTED | E_RETIRE, "halt_entry");
            for (int i = 0; i < hold; i++) cyc(1'b0, rb(), rb(), rb(), rb(), E_HALTED, "halt_hold");
            cyc(1'b1, rb(), rb(), rb(), rb(), E_HALTED, "halt_start");
        end else if (k == K_IN1) begin
            for (int i = 0; i < wio; i++) cyc(rb(), rb(), 1'b0, rb(), rb(), 13'h0, "in_wait");
            cyc(rb(), rb(), 1'b1, rb(), rb(), E_INACK | E_REGWR | E_RETIRE, "in_ack");
        end else if (k == K_OUT1) begin
            for (int i = 0; i < wio; i++) cyc(rb(), rb(), rb(), 1'b0, rb(), E_OUTVLD, "out_wait");
            cyc(rb(), rb(), rb(), 1'b1, rb(), E_OUTVLD | E_RETIRE, "out_done");
        end else begin
            if (k == K_JMP || k == K_JG || k == K_MOVI) begin
                for (int i = 0; i < wo; i++) cyc(rb(), 1'b0, rb(), rb(), rb(), E_MEMRD, "opnd_wait");
                cyc(rb(), 1'b1, rb(), rb(), rb(), E_MEMRD | E_IMMLD | E_PCINC, "operand");
            end
            g  = (gsel < 0) ? rb() : (gsel != 0);
            ex = E_RETIRE;
            case (k)
                K_MOV, K_MOVI: ex = ex | E_REGWR;
                K_ADD:         ex = ex | E_ALUEN | E_REGWR;
                K_SUB:         ex = ex | E_ALUEN | E_ALUSUB | E_REGWR;
                K_JMP:         ex = ex | E_PCLD;
                K_JG:          ex = g ? (ex | E_PCLD) : ex;
                default:       ex = ex;
            endcase
            cyc(rb(), rb(), rb(), rb(), g, ex, "exec");
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ir = 4'h0; gt_flag = 1'b0;
        mem_ready = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 13'h0, "reset_idle");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0, "idle_start");

        run_instr(4'b1000, 0, 0, 0, -1, 0);
        run_instr(4'b1011, 0, 0, 0, 0, 0);
        run_instr(4'b1011, 0, 0, 0, 1, 0);
        run_instr(4'b0001, 0, 0, 5, -1, 0);
        run_instr(4'b1010, 14, 14, 0, -1, 0);
        run_instr(4'b0000, 0, 0, 14, -1, 0);
        run_instr(4'b0001, 0, 0, 14, -1, 0);
        run_instr(4'b1111, 0, 0, 0, -1, 2);
        run_instr(4'b1100, 1, 0, 2, -1, 0);

        for (int n = 0; n < 60; n++)
            run_instr(4'($urandom_range(0, 15)), rw(), rw(), rw(), -1, $urandom_range(0, 2));

        // Reset in the middle of an operand stall
        run_instr(4'b0011, 0, 0, 0, -1, 1);
        ir = 4'b1010;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_MEMRD | E_IRLD | E_PCINC, "fetch_jmp");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0, "decode_jmp");
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_MEMRD, "opnd_at_rst");
        rst = 1'b0;
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 13'h0, "post_rst_idle");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0, "idle_start2");

        // Fifteen stalled fetch cycles trip the watchdog
        ir = 4'b1000;
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, rb(), rb(), rb(), E_MEMRD, "wd_stall");
        for (int i = 0; i < 4; i++) cyc(1'b1, rb(), rb(), rb(), rb(), E_ERR, "err_sticky");
        rst = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_ERR, "err_at_rst");
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0, "err_cleared");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0, "idle_start3");
        run_instr(4'b1001, 0, 0, 0, -1, 0);

        @(negedge clk);
        if (expq.size() != 0) begin
            n_checks++;
            $display("FAIL drain got=%0d exp=0", expq.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_ins_sequencer
`default_nettype wire

// File: doc/ins_sequencer.md
INS_SEQUENCER -- requirements
Module: ins_sequencer

Interface
REQ-001 Parameters (name, default, meaning):
- WAIT_MAX, 15, cycles a handshake may stall before error.
- CW, 4, watchdog counter width; WAIT_MAX SHALL be < 2^CW.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state changes on rising edge.
- rst, in, 1, synchronous, active-high reset.
- start, in, 1, run request; honoured only in IDLE or HALT.
- ir, in, 4, opcode from instruction register; stable from the cycle after ir_ld.
- gt_flag, in, 1, ALU greater flag, sampled in EXEC for jg.
- mem_ready, in, 1, memory read data valid.
- in_valid, in, 1, input port has data.
- out_ready, in, 1, output port accepts data.
- mem_rd, out, 1, memory read request.
- ir_ld, out, 1, load IR from memory data.
- imm_ld, out, 1, load operand register from memory data.
- pc_inc, out, 1, increment PC.
- pc_ld, out, 1, load PC from operand register.
- reg_wr, out, 1, register file write.
- alu_en, out, 1, ALU result valid.
- alu_sub, out, 1, subtract (else add).
- io_in_ack, out, 1, input consumed.
- io_out_vld, out, 1, output data valid.
- retire, out, 1, one-cycle pulse per completed instruction.
- halted, out, 1, in HALT.
- err, out, 1, sticky watchdog error.

Function
REQ-003 States SHALL be exactly: IDLE, FETCH, DECODE, OPERAND, EXEC, WAIT_IO, HALT, ERR.

REQ-004 IDLE: all outputs 0; start=1 -> FETCH.

REQ-005 FETCH: mem_rd=1 held until mem_ready; in the mem_ready cycle ir_ld=1 and pc_inc=1 (Mealy), then -> DECODE.

REQ-006 DECODE: the embedded decoder is enabled; its one-hot result SHALL be latched into an op register at the end of the cycle. Routing:
- jmp, jg, movi -> OPERAND.
- in1, out1 -> WAIT_IO.
- halt -> HALT.
- all others -> EXEC.

REQ-007 OPERAND: mem_rd=1 until mem_ready; in that cycle imm_ld=1 and pc_inc=1, then -> EXEC.

REQ-008 EXEC, one cycle, then -> FETCH with retire=1:
- mova/movb/movc/movd: reg_wr=1.
- add: alu_en=1, reg_wr=1.
- sub: alu_en=1, alu_sub=1, reg_wr=1.
- movi: reg_wr=1.
- jmp: pc_ld=1.
- jg: pc_ld=gt_flag.

REQ-009 WAIT_IO:
- in1: wait for in_valid; in that cycle io_in_ack=1, reg_wr=1, retire=1, then -> FETCH.
- out1: io_out_vld=1 held until out_ready; in that cycle retire=1, then -> FETCH.

REQ-010 HALT: halted=1, retire=1 on the entry cycle only; start=1 -> FETCH (PC not altered).

REQ-011 Watchdog:
- Counter increments each cycle spent stalled in FETCH, OPERAND or WAIT_IO; clears on handshake or state exit.
- Reaching WAIT_MAX -> ERR.

REQ-012 ERR: err=1, all other outputs 0; left only by rst; start ignored.

REQ-013 start asserted outside IDLE/HALT SHALL be ignored.

REQ-014 Latency with zero-wait memory:
- register/ALU instruction: 3 cycles (FETCH, DECODE, EXEC).
- jmp/jg/movi: 4 cycles.
- I/O: 3 cycles plus handshake wait.

REQ-015 ir values 11xx SHALL decode identically to 00xx.

REQ-016 No output SHALL depend combinationally on ir or gt_flag outside the states named above.

Reset
REQ-017 rst=1 at any edge, including mid-handshake, SHALL force IDLE, clear the op register, watchdog and err, and drive all outputs 0 in the following cycle.

Structure
REQ-018 Package ins_pkg SHALL hold the state encoding, op-register bit indices and the WAIT_MAX default.

REQ-019 The decoder SHALL be the existing ins_decode as the sole sub-module; en is driven only in DECODE.

Verification
REQ-020 Directed scenarios:
- Reset, start, ir=1000 (add), mem_ready=1: ir_ld/pc_inc at cycle 1, alu_en+reg_wr at cycle 3, retire at cycle 3.
- ir=1011 (jg), gt_flag=0 then rerun with gt_flag=1: two pc_inc, pc_ld=0 vs pc_ld=1 in EXEC.
- ir=0001 (out1), out_ready low 5 cycles: io_out_vld held 6 cycles, retire in the out_ready cycle, no err.
- mem_ready held low 15 cycles in FETCH: err=1 and stays 1 despite start; rst clears it.
- ir=0011 (halt): halted=1; start -> FETCH; rst asserted in OPERAND -> IDLE, all outputs 0 next cycle.
